// File: rtl/mac_vector_feeder.sv
// Sequencer that buffers one input/weight vector pair and streams it into an
// external signed 8x8 MAC, then captures the returned dot product.
module mac_vector_feeder #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_input_i,
   input  logic [7:0]    wr_weight_i,
   input  logic [AW:0]   len_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [31:0]   result_o,
   output logic          mac_clear_o,
   output logic          mac_enable_o,
   output logic          mac_valid_o,
   output logic [7:0]    mac_input_o,
   output logic [7:0]    mac_weight_o,
   input  logic [31:0]   mac_result_i,
   input  logic          mac_valid_i
);

   localparam int          CW      = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW:0]     len_q, len_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [31:0]     result_q, result_d;
   logic            mac_clear_q, mac_clear_d;
   logic            mac_enable_q, mac_enable_d;
   logic            mac_valid_q, mac_valid_d;
   logic [7:0]      mac_input_q, mac_input_d;
   logic [7:0]      mac_weight_q, mac_weight_d;

   logic [7:0]      in_buf_q [DEPTH];
   logic [7:0]      wt_buf_q [DEPTH];
   logic [AW-1:0]   rd_addr;
   logic            wr_ok;

   assign wr_ok = wr_en_i && (state_q == S_IDLE);

   // Buffers are read combinationally into the operand registers, so a write
   // landing on the start edge is already visible when element 0 is fetched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            in_buf_q[i] <= '0;
            wt_buf_q[i] <= '0;
         end
      end else if (wr_ok) begin
         in_buf_q[wr_addr_i] <= wr_input_i;
         wt_buf_q[wr_addr_i] <= wr_weight_i;
      end
   end

   assign rd_addr = (state_q == S_CLEAR) ? '0 : idx_q + AW'(1);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      mac_clear_d  = 1'b0;
      mac_enable_d = 1'b0;
      mac_valid_d  = 1'b0;
      mac_input_d  = '0;
      mac_weight_d = '0;

      // Outputs are computed for the state being entered, then registered.
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_i == '0 || len_i > MAX_LEN) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = S_CLEAR;
                  len_d       = len_i;
                  idx_d       = '0;
                  busy_d      = 1'b1;
                  mac_clear_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            busy_d = 1'b1;
            if (idx_q == '0) begin
               idx_d       = AW'(1);
               mac_clear_d = 1'b1;
            end else begin
               state_d      = S_STREAM;
               idx_d        = '0;
               mac_enable_d = 1'b1;
               mac_valid_d  = (len_q == (AW+1)'(1));
               mac_input_d  = in_buf_q[rd_addr];
               mac_weight_d = wt_buf_q[rd_addr];
            end
         end
         S_STREAM: begin
            busy_d = 1'b1;
            if ({1'b0, idx_q} + (AW+1)'(1) == len_q) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               idx_d        = rd_addr;
               mac_enable_d = 1'b1;
               mac_valid_d  = ({1'b0, idx_q} + (AW+1)'(2) == len_q);
               mac_input_d  = in_buf_q[rd_addr];
               mac_weight_d = wt_buf_q[rd_addr];
            end
         end
         S_WAIT: begin
            busy_d = 1'b1;
            if (mac_valid_i) begin
               result_d = mac_result_i;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               result_d = '0;
               err_d    = 1'b1;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         result_q     <= '0;
         mac_clear_q  <= 1'b1;
         mac_enable_q <= 1'b0;
         mac_valid_q  <= 1'b0;
         mac_input_q  <= '0;
         mac_weight_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         result_q     <= result_d;
         mac_clear_q  <= mac_clear_d;
         mac_enable_q <= mac_enable_d;
         mac_valid_q  <= mac_valid_d;
         mac_input_q  <= mac_input_d;
         mac_weight_q <= mac_weight_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign result_o     = result_q;
   assign mac_clear_o  = mac_clear_q;
   assign mac_enable_o = mac_enable_q;
   assign mac_valid_o  = mac_valid_q;
   assign mac_input_o  = mac_input_q;
   assign mac_weight_o = mac_weight_q;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Directed bench for mac_vector_feeder with a behavioural MAC (2-cycle valid
// latency) attached; expected results are hand-computed constants.
module tb_mac_vector_feeder;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        wr_en_i = 1'b0;
   logic [3:0]  wr_addr_i = '0;
   logic [7:0]  wr_input_i = '0;
   logic [7:0]  wr_weight_i = '0;
   logic [4:0]  len_i = '0;
   logic        start_i = 1'b0;
   logic        busy_o, done_o, err_o;
   logic [31:0] result_o;
   logic        mac_clear_o, mac_enable_o, mac_valid_o;
   logic [7:0]  mac_input_o, mac_weight_o;
   logic [31:0] mac_result_i;
   logic        mac_valid_i;

   int n_cmp = 0;
   int n_bad = 0;

   mac_vector_feeder #(.DEPTH(16), .AW(4), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
      .wr_input_i(wr_input_i), .wr_weight_i(wr_weight_i),
      .len_i(len_i), .start_i(start_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
      .mac_clear_o(mac_clear_o), .mac_enable_o(mac_enable_o),
      .mac_valid_o(mac_valid_o), .mac_input_o(mac_input_o),
      .mac_weight_o(mac_weight_o), .mac_result_i(mac_result_i),
      .mac_valid_i(mac_valid_i)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural MAC: clear-dominant accumulator, valid delayed by two cycles.
   logic signed [31:0] acc_q, op_a, op_b;
   logic               v1_q, v2_q;
   logic               mac_kill = 1'b0;
   assign op_a = {{24{mac_input_o[7]}}, mac_input_o};
   assign op_b = {{24{mac_weight_o[7]}}, mac_weight_o};
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0; v1_q <= 1'b0; v2_q <= 1'b0;
      end else begin
         if (mac_clear_o)       acc_q <= '0;
         else if (mac_enable_o) acc_q <= acc_q + op_a * op_b;
         v1_q <= mac_valid_o & mac_enable_o;
         v2_q <= v1_q;
      end
   end
   assign mac_result_i = acc_q;
   assign mac_valid_i  = v2_q & ~mac_kill;

   logic        done_log [64], err_log [64], clr_log [64];
   logic        en_log [64], val_log [64], busy_log [64];
   logic [31:0] res_log [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic wr(input int a, input int x, input int w);
      wr_en_i = 1'b1; wr_addr_i = 4'(a); wr_input_i = 8'(x); wr_weight_i = 8'(w);
      @(posedge clk_i); #1;
      wr_en_i = 1'b0;
   endtask

   task automatic launch(input int len);
      len_i = 5'(len); start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // Log one sample per cycle T+n (n=1..ncyc) after the start edge T.
   task automatic watch(input int ncyc, input int poke_at, input int drop_at);
      for (int n = 0; n < 64; n++) begin
         done_log[n] = 0; err_log[n] = 0; clr_log[n] = 0;
         en_log[n] = 0; val_log[n] = 0; busy_log[n] = 0; res_log[n] = '0;
      end
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk_i);
         done_log[n] = done_o; err_log[n] = err_o; clr_log[n] = mac_clear_o;
         en_log[n] = mac_enable_o; val_log[n] = mac_valid_o;
         busy_log[n] = busy_o; res_log[n] = result_o;
         if (n == drop_at) start_i = 1'b0;
         if (n == poke_at) begin
            start_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 4'd0;
            wr_input_i = 8'd100; wr_weight_i = 8'd100;
         end
         if (poke_at != 0 && n == poke_at + 1) begin
            start_i = 1'b0; wr_en_i = 1'b0;
         end
      end
   endtask

   task automatic analyze(input string job, input int len, input int exp_n,
                          input logic [31:0] exp_res, input int exp_err);
      int dn, nclr, nen, nval, vpos, nerr, ndone;
      dn = 0; nclr = 0; nen = 0; nval = 0; vpos = 0; nerr = 0; ndone = 0;
      for (int n = 1; n < 63; n++) begin
         if (done_log[n]) ndone++;
         if (done_log[n] && dn == 0) dn = n;
         if (err_log[n]) nerr++;
         if (ndone == 0 || done_log[n]) begin
            if (clr_log[n]) nclr++;
            if (en_log[n]) nen++;
            if (val_log[n]) begin nval++; vpos = n; end
         end
      end
      check({job, ".done_cycle"}, dn, exp_n);
      check({job, ".done_count"}, ndone, 1);
      check({job, ".result"}, res_log[dn], exp_res);
      check({job, ".err_at_done"}, {31'd0, err_log[dn]}, exp_err);
      check({job, ".err_count"}, nerr, exp_err);
      check({job, ".clear_cycles"}, nclr, 2);
      check({job, ".stream_cycles"}, nen, len);
      check({job, ".valid_count"}, nval, 1);
      check({job, ".valid_cycle"}, vpos, len + 2);
      check({job, ".busy_first"}, {31'd0, busy_log[1]}, 1);
      check({job, ".busy_after"}, {31'd0, busy_log[dn + 1]}, 0);
   endtask

   task automatic reject(input string job, input int len, input logic [31:0] held);
      int nerr, nbusy, ndone;
      nerr = 0; nbusy = 0; ndone = 0;
      launch(len);
      watch(8, 0, 0);
      for (int n = 1; n <= 8; n++) begin
         if (err_log[n]) nerr++;
         if (busy_log[n]) nbusy++;
         if (done_log[n]) ndone++;
      end
      check({job, ".err_first"}, {31'd0, err_log[1]}, 1);
      check({job, ".err_count"}, nerr, 1);
      check({job, ".busy_count"}, nbusy, 0);
      check({job, ".done_count"}, ndone, 0);
      check({job, ".result_held"}, res_log[8], held);
      $display("job %s: len=%0d err=%0d busy=%0d done=%0d", job, len, nerr, nbusy, ndone);
   endtask

   task automatic load_basic();
      for (int i = 0; i < 4; i++) wr(i, i + 1, i + 5);
   endtask

   initial begin
      int nclr_a, ndone_b;

      // Reset values
      repeat (2) @(posedge clk_i);
      #1;
      check("rst.busy", {31'd0, busy_o}, 0);
      check("rst.done", {31'd0, done_o}, 0);
      check("rst.err", {31'd0, err_o}, 0);
      check("rst.result", result_o, 0);
      check("rst.mac_clear", {31'd0, mac_clear_o}, 1);
      check("rst.mac_enable", {31'd0, mac_enable_o}, 0);
      check("rst.mac_valid", {31'd0, mac_valid_o}, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("idle.mac_clear", {31'd0, mac_clear_o}, 0);

      // Basic dot product; element 3 written on the start edge itself
      for (int i = 0; i < 3; i++) wr(i, i + 1, i + 5);
      wr_en_i = 1'b1; wr_addr_i = 4'd3; wr_input_i = 8'd4; wr_weight_i = 8'd8;
      len_i = 5'd4; start_i = 1'b1;
      @(posedge clk_i); #1;
      wr_en_i = 1'b0; start_i = 1'b0;
      watch(14, 0, 0);
      analyze("basic", 4, 9, 32'd70, 0);
      $display("job basic: len=4 result=%0d", $signed(result_o));

      // Start and write while busy are ignored
      launch(4);
      watch(14, 4, 0);
      analyze("busy_poke", 4, 9, 32'd70, 0);
      launch(4);
      watch(14, 0, 0);
      analyze("busy_rerun", 4, 9, 32'd70, 0);
      $display("job busy_poke: result=%0d", $signed(result_o));

      // Signed extremes over the full depth
      for (int i = 0; i < 16; i++) wr(i, -128, -128);
      launch(16);
      watch(26, 0, 0);
      analyze("ext_pos", 16, 21, 32'd262144, 0);
      $display("job ext_pos: result=%0d", $signed(result_o));
      for (int i = 0; i < 16; i++) wr(i, -128, 127);
      launch(16);
      watch(26, 0, 0);
      analyze("ext_neg", 16, 21, -32'sd260096, 0);
      $display("job ext_neg: result=%0d", $signed(result_o));

      // Rejected lengths
      reject("len0", 0, -32'sd260096);
      reject("len17", 17, -32'sd260096);

      // MAC never answers: timeout after TIMEOUT+1 WAIT cycles
      mac_kill = 1'b1;
      launch(4);
      watch(20, 0, 0);
      analyze("timeout", 4, 16, 32'd0, 1);
      mac_kill = 1'b0;
      $display("job timeout: result=%0d", $signed(result_o));

      // Back-to-back with start held: second job must not include the first sum
      wr(0, 1, 3);
      wr(1, 2, 4);
      len_i = 5'd2; start_i = 1'b1;
      @(posedge clk_i); #1;
      watch(18, 0, 9);
      nclr_a = 0; ndone_b = 0;
      for (int n = 1; n <= 18; n++) begin
         if (clr_log[n]) nclr_a++;
         if (done_log[n]) ndone_b++;
      end
      check("b2b.done_first", {31'd0, done_log[7]}, 1);
      check("b2b.result_first", res_log[7], 32'd11);
      check("b2b.idle_gap", {31'd0, busy_log[8]}, 0);
      check("b2b.clear_second", {30'd0, clr_log[9], clr_log[10]}, 3);
      check("b2b.done_second", {31'd0, done_log[15]}, 1);
      check("b2b.result_second", res_log[15], 32'd11);
      check("b2b.clear_total", nclr_a, 4);
      check("b2b.done_total", ndone_b, 2);
      $display("job b2b: dones=%0d clears=%0d result=%0d", ndone_b, nclr_a, $signed(result_o));

      // Reset in the middle of STREAM
      load_basic();
      launch(4);
      watch(4, 0, 0);
      #2 rst_i = 1'b1;
      #1;
      check("midrst.busy", {31'd0, busy_o}, 0);
      check("midrst.result", result_o, 0);
      check("midrst.mac_clear", {31'd0, mac_clear_o}, 1);
      check("midrst.mac_enable", {31'd0, mac_enable_o}, 0);
      check("midrst.mac_input", {24'd0, mac_input_o}, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      load_basic();
      launch(4);
      watch(14, 0, 0);
      analyze("after_rst", 4, 9, 32'd70, 0);
      $display("job after_rst: result=%0d", $signed(result_o));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
